// File: rtl/bist_march_gen.sv
// bist_march_gen -- March C- command sequencer for memory BIST.
//
// On start it drives the full March C- stream (10*N single-cycle ops) onto
// the memory bus, then drains the expected-data pipe and raises done.
// Every read also pushes its expected data into a RD_LAT-deep pipe so that
// exp_valid/exp_data line up with the memory's rdata for that read.
//
// Element order (D0 = background, D1 = ~D0):
//   E0 up   w D0        E3 down r D0, w D1
//   E1 up   r D0, w D1  E4 down r D1, w D0
//   E2 up   r D1, w D0  E5 up   r D0
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               level, sampled only in IDLE and DONE
//   mem_addr/mem_wdata  memory address / write data (wdata holds on reads)
//   mem_we/mem_re       write / read strobe, exactly one per RUN cycle
//   exp_data/exp_valid  expected read data, RD_LAT cycles after mem_re
//   busy                high while running or draining
//   done                high once the stream has fully drained
//
// Build option:
//   BIST_CHECKERBOARD_EN  D0 becomes a 0101.. / 1010.. checkerboard keyed on
//                         address bit 0 instead of all zeros.
module bist_march_gen #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] exp_data,
  output logic              exp_valid,
  output logic              busy,
  output logic              done
);

`ifdef BIST_CHECKERBOARD_EN
  localparam bit CB_EN = 1'b1;
`else
  localparam bit CB_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [2:0]        ELEM_LAST = 3'd5;
  localparam logic [2:0]        DRAIN_END = 3'(RD_LAT - 1);
  localparam logic [DATA_W-1:0] CB_PAT    = DATA_W'({(DATA_W/2){2'b01}});

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Decoded operation for an (element, phase) pair.
  typedef struct packed {
    logic wr;   // 1 = write, 0 = read
    logic inv;  // 1 = D1, 0 = D0
  } op_dec_t;

  // Phase 0 of E1..E5 is the read, phase 1 of E1..E4 is the write; E0 only
  // writes. Reads of E2/E4 expect D1, writes of E1/E3 store D1.
  function automatic op_dec_t decode(input logic [2:0] e, input logic ph);
    op_dec_t d;
    d.wr  = (e == 3'd0) || ph;
    d.inv = ph ? ((e == 3'd1) || (e == 3'd3))
               : ((e == 3'd2) || (e == 3'd4));
    return d;
  endfunction

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic two_op(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  // Background pattern D0 at a given address.
  function automatic logic [DATA_W-1:0] bg(input logic [ADDR_W-1:0] a);
    return CB_EN ? (CB_PAT ^ {DATA_W{a[0]}}) : '0;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                     state_q, state_d;
  logic [2:0]                 elem_q, elem_d;
  logic                       ph_q, ph_d;
  logic [2:0]                 drain_q, drain_d;
  logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]          mem_wdata_q, mem_wdata_d;
  logic                       mem_we_q, mem_we_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  // Stage 0 of the valid pipe is the read strobe itself; stage RD_LAT is
  // exp_valid. Data stages only load alongside a valid, so the last stage
  // naturally holds the most recent expected value.
  logic [RD_LAT:0]              vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:0][DATA_W-1:0]  dat_pipe_q, dat_pipe_d;

  logic                       issue;
  logic [2:0]                 elem_nx;
  logic                       elem_end;
  op_dec_t                    dec;
  logic [DATA_W-1:0]          op_data;

  // ---------------------------------------------------------------------
  // Next state / next op
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    ph_d       = ph_q;
    drain_d    = drain_q;
    mem_addr_d = mem_addr_q;
    issue      = 1'b0;
    elem_nx    = elem_q + 3'd1;
    // Last address of the current element in its own direction.
    elem_end   = is_down(elem_q) ? (mem_addr_q == '0) : (mem_addr_q == ADDR_MAX);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          elem_d     = 3'd0;
          ph_d       = 1'b0;
          mem_addr_d = '0;
          issue      = 1'b1;
        end
      end
      S_RUN: begin
        // E5 is single-op and ascending, so its top address is the final op.
        if (elem_q == ELEM_LAST && mem_addr_q == ADDR_MAX) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          issue = 1'b1;
          if (two_op(elem_q) && !ph_q) begin
            ph_d = 1'b1;
          end else begin
            ph_d = 1'b0;
            if (elem_end) begin
              // Step straight into the next element's first address; the
              // address counter never wraps.
              elem_d     = elem_nx;
              mem_addr_d = is_down(elem_nx) ? ADDR_MAX : '0;
            end else begin
              mem_addr_d = is_down(elem_q) ? (mem_addr_q - 1'b1)
                                           : (mem_addr_q + 1'b1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_END) state_d = S_DONE;
        else                      drain_d = drain_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registered bus outputs and expected-data pipe
  // ---------------------------------------------------------------------
  always_comb begin
    dec     = decode(elem_d, ph_d);
    op_data = dec.inv ? ~bg(mem_addr_d) : bg(mem_addr_d);

    mem_we_d    = issue & dec.wr;
    mem_wdata_d = (issue && dec.wr) ? op_data : mem_wdata_q;

    vld_pipe_d    = '0;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[0] = issue & ~dec.wr;
    if (issue && !dec.wr) dat_pipe_d[0] = op_data;
    for (int i = 1; i <= RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      if (vld_pipe_q[i-1]) dat_pipe_d[i] = dat_pipe_q[i-1];
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      ph_q        <= 1'b0;
      drain_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      vld_pipe_q  <= '0;
      dat_pipe_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      ph_q        <= ph_d;
      drain_q     <= drain_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      vld_pipe_q  <= vld_pipe_d;
      dat_pipe_q  <= dat_pipe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = vld_pipe_q[0];
  assign exp_valid = vld_pipe_q[RD_LAT];
  assign exp_data  = dat_pipe_q[RD_LAT];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bist_march_gen.sv
// tb_bist_march_gen -- two instances (RD_LAT=1 and RD_LAT=3) driven by the
// same start/reset. The expected command stream is built once as a list of
// ops from the March C- element table; a per-instance cycle counter since
// the start edge indexes that list to give every output on every cycle.
module tb_bist_march_gen;
  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int N    = 16;
  localparam int NOPS = 10 * N;
  localparam int RL0  = 1;
  localparam int RL1  = 3;
`ifdef BIST_CHECKERBOARD_EN
  localparam bit CB = 1'b1;
`else
  localparam bit CB = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0][AW-1:0] mem_addr;
  logic [1:0][DW-1:0] mem_wdata, exp_data;
  logic [1:0]         mem_we, mem_re, exp_valid, busy, done;

  always #5 clk = ~clk;

  bist_march_gen #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_we(mem_we[0]), .mem_re(mem_re[0]),
    .exp_data(exp_data[0]), .exp_valid(exp_valid[0]),
    .busy(busy[0]), .done(done[0]));

  bist_march_gen #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_we(mem_we[1]), .mem_re(mem_re[1]),
    .exp_data(exp_data[1]), .exp_valid(exp_valid[1]),
    .busy(busy[1]), .done(done[1]));

  typedef struct {
    bit          we;
    int          addr;
    logic [DW-1:0] data;
  } op_t;

  op_t ops[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int rl_of(input int k);
    return (k == 0) ? RL0 : RL1;
  endfunction

  function automatic int done_t(input int k);
    return NOPS + rl_of(k) + 1;
  endfunction

  function automatic logic [DW-1:0] bg(input int a);
    if (!CB) return 8'h00;
    return (a % 2 == 1) ? 8'hAA : 8'h55;
  endfunction

  // March C- as a table: ops per element, direction, and per-op kind/polarity.
  task automatic build_ops();
    int nops[6]    = '{1, 2, 2, 2, 2, 1};
    bit dn[6]      = '{0, 0, 0, 1, 1, 0};
    bit wr[6][2]   = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
    bit pol[6][2]  = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
    op_t o;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < nops[e]; j++) begin
          o.addr = dn[e] ? (N - 1 - i) : i;
          o.we   = wr[e][j];
          o.data = pol[e][j] ? ~bg(o.addr) : bg(o.addr);
          ops.push_back(o);
        end
  endtask

  // Model state: cycles since the accepted start edge.
  bit run[2];
  int t[2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        run[k] <= 1'b0;
        t[k]   <= 0;
      end else if (start && (!run[k] || t[k] >= done_t(k))) begin
        run[k] <= 1'b1;
        t[k]   <= 1;
      end else if (run[k]) begin
        t[k] <= t[k] + 1;
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  logic [AW-1:0] m_ad[2];
  logic [DW-1:0] m_wd[2], m_ex[2];
  int c_we[2], c_re[2], c_ev[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit e_we, e_re, e_ev, e_busy, e_done;
      int tt, rt;
      e_we = 0; e_re = 0; e_ev = 0; e_busy = 0; e_done = 0;
      if (rst || !run[k]) begin
        m_ad[k] = '0; m_wd[k] = '0; m_ex[k] = '0;
      end else begin
        tt = t[k];
        rt = tt - rl_of(k);
        if (tt >= 1 && tt <= NOPS) begin
          e_we    = ops[tt-1].we;
          e_re    = !ops[tt-1].we;
          m_ad[k] = AW'(ops[tt-1].addr);
          if (e_we) m_wd[k] = ops[tt-1].data;
        end
        if (rt >= 1 && rt <= NOPS) begin
          if (!ops[rt-1].we) begin
            e_ev    = 1;
            m_ex[k] = ops[rt-1].data;
          end
        end
        e_busy = (tt >= 1) && (tt <= NOPS + rl_of(k));
        e_done = tt > NOPS + rl_of(k);
        if (tt == 1) begin c_we[k] = 0; c_re[k] = 0; c_ev[k] = 0; end
        c_we[k] += int'(mem_we[k]);
        c_re[k] += int'(mem_re[k]);
        c_ev[k] += int'(exp_valid[k]);
        if (tt == done_t(k)) begin
          chk("we_count", k, c_we[k], 80);
          chk("re_count", k, c_re[k], 80);
          chk("ev_count", k, c_ev[k], 80);
        end
      end
      chk("mem_we",    k, mem_we[k],    e_we);
      chk("mem_re",    k, mem_re[k],    e_re);
      chk("exp_valid", k, exp_valid[k], e_ev);
      chk("busy",      k, busy[k],      e_busy);
      chk("done",      k, done[k],      e_done);
      chk("mem_addr",  k, mem_addr[k],  m_ad[k]);
      chk("mem_wdata", k, mem_wdata[k], m_wd[k]);
      chk("exp_data",  k, exp_data[k],  m_ex[k]);
    end
  end

  // Start a run, sprinkle ignored start pulses while running, and pin the
  // done-rise cycle of each instance.
  task automatic run_once();
    int cyc, d0, d1;
    d0 = 0; d1 = 0;
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while ((d0 == 0 || d1 == 0) && cyc < 400) begin
      if (done[0] && d0 == 0) d0 = cyc;
      if (done[1] && d1 == 0) d1 = cyc;
      start = (cyc < 150) ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", 0, d0, 164 - 2);
    chk("done_cycle", 1, d1, 164);
  endtask

  // Assert reset mid-cycle and require every output to drop at once.
  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_addr",  k, mem_addr[k],  0);
      chk("rst_wdata", k, mem_wdata[k], 0);
      chk("rst_we",    k, mem_we[k],    0);
      chk("rst_re",    k, mem_re[k],    0);
      chk("rst_edata", k, exp_data[k],  0);
      chk("rst_ev",    k, exp_valid[k], 0);
      chk("rst_busy",  k, busy[k],      0);
      chk("rst_done",  k, done[k],      0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int wcnt;
    build_ops();

    // Pin the model against hand-derived values.
    chk("model_size", 0, ops.size(), 160);
    wcnt = 0;
    foreach (ops[i]) wcnt += int'(ops[i].we);
    chk("model_writes", 0, wcnt, 80);
    chk("model_op0_we",   0, ops[0].we,   1);
    chk("model_op0_data", 0, ops[0].data, CB ? 8'h55 : 8'h00);
    chk("model_op1_data", 0, ops[1].data, CB ? 8'hAA : 8'h00);
    chk("model_op80_we",  0, ops[80].we,   0);
    chk("model_op80_adr", 0, ops[80].addr, 15);
    chk("model_op81_we",  0, ops[81].we,   1);
    chk("model_op81_adr", 0, ops[81].addr, 15);
    chk("model_op81_dat", 0, ops[81].data, CB ? 8'h55 : 8'hFF);
    chk("model_op82_adr", 0, ops[82].addr, 14);
    chk("model_op159_adr", 0, ops[159].addr, 15);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Full run with ignored start noise, then linger in DONE.
    run_once();
    repeat (4) @(negedge clk);

    // Restart from DONE, reset around cycle 50, then a clean run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (48) @(negedge clk);
    async_reset();
    repeat (3) @(negedge clk);
    run_once();
    repeat (3) @(negedge clk);

    // Reset at a random point (possibly in DRAIN), then a final run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(5, 165)) @(negedge clk);
    async_reset();
    repeat (2) @(negedge clk);
    run_once();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_march_gen.md
Name: bist_march_gen

Overview:
- March C- pattern sequencer for the BIST: upstream of the memory under test and the response comparator.
- On `start` it issues the full March C- command stream (address, write data, write/read strobes) to the memory.
- For every read it also issues the expected data, delayed to line up with the memory read latency, for the downstream comparator.
- Reports `busy` and `done` to the BIST top; the comparator owns `fail`.

Parameters:
- ADDR_W, 4, memory address width; N = 2**ADDR_W words.
- DATA_W, 8, memory data width.
- RD_LAT, 1, memory read latency in cycles (legal 1..4); delay from `mem_re` to `exp_valid`.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level; sampled only in IDLE and DONE.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_we  output  1  write strobe, one op per cycle.
- mem_re  output  1  read strobe, one op per cycle.
- exp_data  output  DATA_W  expected read data for the comparator.
- exp_valid  output  1  exp_data is valid this cycle; aligned to the memory rdata of the read issued RD_LAT cycles earlier.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE; held until the next start or reset.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including mem_addr, mem_wdata, exp_data and the exp delay pipe. Reset mid-run aborts immediately; no partial done.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 at an edge -> RUN; element=0, op=0, addr=0.
  - RUN: one memory op per cycle; exactly one of mem_we/mem_re high every RUN cycle; never both.
  - Last op issued -> DRAIN.
  - DRAIN: RD_LAT cycles, no mem ops, exp pipe flushes -> DONE.
  - DONE: done=1, busy=0. start=1 -> RUN (restart, done cleared same edge).
- start while in RUN or DRAIN is ignored.
- March elements, in order (D0 = background 0, D1 = ~D0):
  - E0: up, w D0.
  - E1: up, r D0 then w D1.
  - E2: up, r D1 then w D0.
  - E3: down, r D0 then w D1.
  - E4: down, r D1 then w D0.
  - E5: up, r D0.
- Ordering rules:
  - "up" = addr 0..N-1; "down" = addr N-1..0.
  - Both ops of an element complete at one address before the address steps.
  - Element boundary: next element starts at its first address on the very next cycle; no bubble.
- Totals per run: 10N ops, 5N writes, 5N reads, RUN length exactly 10N cycles.
- Timing:
  - Outputs are registered.
  - Op k (k=0..10N-1) appears on the bus in cycle k+1 after the start-sampling edge.
  - exp_valid/exp_data for a read in cycle c appear in cycle c+RD_LAT.
  - done rises in cycle 10N+RD_LAT+1.
- mem_wdata holds its last value on read cycles; exp_data holds its last value when exp_valid=0.
- Address counter wraps are never visible: element change occurs instead of wrap.

Optional Feature:
- BIST_CHECKERBOARD_EN defined:
  - D0 = {DATA_W/2{2'b01}} XOR {DATA_W{mem_addr[0]}}, i.e. 0x55 at even and 0xAA at odd addresses for DATA_W=8.
  - D1 = ~D0 at the same address.
  - Exp data uses the address of the originating read.
- Not defined: D0 = all zeros, D1 = all ones.
- Sequence timing is identical in both builds.

Test Plan:
1. Reset 15 ns, start high 15 ns (defaults: N=16, RD_LAT=1):
   - Cycles 1..16: mem_we=1, addr 0..15, wdata 0x00.
   - done rises in cycle 162; busy is high in cycles 1..161.
2. Count the full run:
   - Exactly 80 mem_we pulses, 80 mem_re pulses, 80 exp_valid pulses.
   - exp_data sequence is 16x00, 16xFF, 16x00, 16xFF, 16x00.
3. E3 boundary check:
   - Cycles 81/82: re @ addr 15 then we 0xFF @ addr 15.
   - Cycle 83: re @ addr 14.
   - Every exp_valid is exactly one cycle after its mem_re.
4. Assert rst at cycle 50:
   - All outputs 0 immediately (before the next edge).
   - State IDLE; done stays 0.
   - A new start restarts at E0 addr 0.
5. Ignored start, then restart:
   - Re-pulse start during RUN: no effect, done still at cycle 162.
   - Pulse start while in DONE: done drops, new 160-op run begins.
6. RD_LAT=3, BIST_CHECKERBOARD_EN defined:
   - E0 writes 0x55/0xAA alternating.
   - exp_valid lags mem_re by 3 cycles.
   - done rises in cycle 164.
